// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one SDRAM controller port among NUM_PORTS line clients
// Optional: define SDRAM_ARB_PORT0_PRIORITY_EN to give port 0 (display) strict priority.
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int AW        = 25,
    parameter int DW        = 128
) (
    input  logic                    iclk,
    input  logic                    ireset,
    input  logic [NUM_PORTS-1:0]    ireq,
    input  logic [NUM_PORTS-1:0]    iwe,
    input  logic [NUM_PORTS*AW-1:0] iaddr,
    input  logic [NUM_PORTS*DW-1:0] iwdata,
    output logic [NUM_PORTS-1:0]    oack,
    output logic [DW-1:0]           ordata,
    output logic [NUM_PORTS-1:0]    ogrant,
    output logic                    obusy,
    output logic                    owrite_req,
    output logic [AW-1:0]           owrite_address,
    output logic [DW-1:0]           owrite_data,
    input  logic                    iwrite_ack,
    output logic                    oread_req,
    output logic [AW-1:0]           oread_address,
    input  logic [DW-1:0]           iread_data,
    input  logic                    iread_ack
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
    localparam bit PORT0_PRIO = 1'b1;
`else
    localparam bit PORT0_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          last;
    logic [IW-1:0]          win;
    logic                   we_l;
    logic [IW-1:0]          pick;
    logic                   pick_valid;
    logic                   pick_prio;
    logic                   mem_ack;
    logic [NUM_PORTS-1:0]   pick_onehot;
    logic [NUM_PORTS-1:0]   win_onehot;
    int                     pick_base_a;
    int                     pick_base_d;

    // Search starts one past the last winner so every port is reached within NUM_PORTS-1 grants.
    always_comb begin
        int j;
        j          = 0;
        pick       = '0;
        pick_valid = 1'b0;
        pick_prio  = 1'b0;
        if (PORT0_PRIO && ireq[0]) begin
            pick_valid = 1'b1;
            pick_prio  = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_PORTS; i++) begin
                j = int'(last) + i;
                if (j >= NUM_PORTS) begin
                    j = j - NUM_PORTS;
                end
                if (!pick_valid && ireq[IW'(j)]) begin
                    pick       = IW'(j);
                    pick_valid = 1'b1;
                end
            end
        end
    end

    assign pick_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick;
    assign win_onehot  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win;
    assign pick_base_a = int'(pick) * AW;
    assign pick_base_d = int'(pick) * DW;
    assign mem_ack     = we_l ? iwrite_ack : iread_ack;
    assign obusy       = (state != S_IDLE);

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request strobes are registered and drop at the ack edge so the controller never re-issues.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            last           <= IW'(NUM_PORTS - 1);
            win            <= '0;
            we_l           <= 1'b0;
            oack           <= '0;
            ogrant         <= '0;
            ordata         <= '0;
            owrite_req     <= 1'b0;
            owrite_address <= '0;
            owrite_data    <= '0;
            oread_req      <= 1'b0;
            oread_address  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    oack <= '0;
                    if (pick_valid) begin
                        win    <= pick;
                        we_l   <= iwe[pick];
                        ogrant <= pick_onehot;
                        if (!pick_prio) begin
                            last <= pick;
                        end
                        if (iwe[pick]) begin
                            owrite_req     <= 1'b1;
                            owrite_address <= iaddr[pick_base_a +: AW];
                            owrite_data    <= iwdata[pick_base_d +: DW];
                        end else begin
                            oread_req     <= 1'b1;
                            oread_address <= iaddr[pick_base_a +: AW];
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        owrite_req <= 1'b0;
                        oread_req  <= 1'b0;
                        oack       <= win_onehot;
                        if (!we_l) begin
                            ordata <= iread_data;
                        end
                    end
                end
                S_DONE: begin
                    oack   <= '0;
                    ogrant <= '0;
                end
                default: begin
                    oack       <= '0;
                    ogrant     <= '0;
                    owrite_req <= 1'b0;
                    oread_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter with a latency-programmable controller model
module tb_sdram_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 25;
    localparam int DW = 128;

    logic              iclk = 1'b0;
    logic              ireset;
    logic [NP-1:0]     ireq;
    logic [NP-1:0]     iwe;
    logic [NP*AW-1:0]  iaddr;
    logic [NP*DW-1:0]  iwdata;
    logic [NP-1:0]     oack;
    logic [DW-1:0]     ordata;
    logic [NP-1:0]     ogrant;
    logic              obusy;
    logic              owrite_req;
    logic [AW-1:0]     owrite_address;
    logic [DW-1:0]     owrite_data;
    logic              iwrite_ack;
    logic              oread_req;
    logic [AW-1:0]     oread_address;
    logic [DW-1:0]     iread_data;
    logic              iread_ack;

    logic              mdl_wack, mdl_rack, man_wack, man_rack;
    logic              ctl_en;
    int                ctl_lat;
    logic [DW-1:0]     ctl_rdata;

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t              sb[$];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                last_ack_cyc = -10;
    int                req_cycles = 0;
    int                ack_total = 0;
    bit                both_seen = 1'b0;
    bit                rd_seen = 1'b0;
    logic              prev_req = 1'b0;
    logic [NP-1:0]     prev_ack = '0;
    logic [DW-1:0]     last_rd = '0;

    assign iwrite_ack = mdl_wack | man_wack;
    assign iread_ack  = mdl_rack | man_rack;
    assign iread_data = iread_ack ? ctl_rdata : '0;

    always #5 iclk = ~iclk;

    sdram_port_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW)) dut (
        .iclk(iclk), .ireset(ireset), .ireq(ireq), .iwe(iwe), .iaddr(iaddr), .iwdata(iwdata),
        .oack(oack), .ordata(ordata), .ogrant(ogrant), .obusy(obusy),
        .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
        .iwrite_ack(iwrite_ack), .oread_req(oread_req), .oread_address(oread_address),
        .iread_data(iread_data), .iread_ack(iread_ack)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] onehot(input int p);
        return DW'(1) << p;
    endfunction

    always @(posedge iclk) begin
        if (iwrite_ack || iread_ack) last_ack_cyc = cyc;
        cyc++;
    end

    // Controller model: acks ctl_lat cycles after it first sees a request, one-cycle pulse.
    always @(negedge iclk) begin : ctl_model
        int cnt;
        if (ireset || !ctl_en) begin
            mdl_wack = 1'b0; mdl_rack = 1'b0; cnt = 0;
        end else if (mdl_wack || mdl_rack) begin
            mdl_wack = 1'b0; mdl_rack = 1'b0; cnt = 0;
        end else if (owrite_req || oread_req) begin
            cnt++;
            if (cnt == ctl_lat) begin
                if (owrite_req) mdl_wack = 1'b1;
                else mdl_rack = 1'b1;
            end
        end
    end

    always @(negedge iclk) begin : monitor
        logic req_now;
        txn_t t;
        req_now = owrite_req | oread_req;
        if (owrite_req && oread_req) both_seen = 1'b1;
        if (oread_req) rd_seen = 1'b1;
        if (req_now) req_cycles++;
        if (req_now && !prev_req) begin
            if (sb.size() == 0) begin
                check("unexp_req", DW'(1), DW'(0));
            end else begin
                t = sb[0];
                check("grant", DW'(ogrant), onehot(t.port));
                if (t.we) begin
                    check("wr_req", DW'(owrite_req), DW'(1));
                    check("wr_addr", DW'(owrite_address), DW'(t.addr));
                    check("wr_data", owrite_data, t.wdata);
                end else begin
                    check("rd_req", DW'(oread_req), DW'(1));
                    check("rd_addr", DW'(oread_address), DW'(t.addr));
                end
            end
        end
        if (oack != '0) begin
            ack_total++;
            check("ack_single", DW'(prev_ack), DW'(0));
            check("ack_lat", DW'(cyc), DW'(last_ack_cyc + 1));
            if (sb.size() == 0) begin
                check("stray_ack", DW'(oack), DW'(0));
            end else begin
                t = sb.pop_front();
                check("ack_port", DW'(oack), onehot(t.port));
                if (t.we) begin
                    check("wr_keeps_rd", ordata, last_rd);
                end else begin
                    check("rd_data", ordata, ctl_rdata);
                    last_rd = ctl_rdata;
                end
            end
        end
        prev_req = req_now;
        prev_ack = oack;
    end

    function automatic txn_t mk(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.port = p; t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    task automatic setup_port(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iwe[p] = we;
        iaddr[p*AW +: AW] = a;
        iwdata[p*DW +: DW] = d;
    endtask

    task automatic do_txn(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        sb.push_back(mk(p, we, a, d));
        setup_port(p, we, a, d);
        ireq[p] = 1'b1;
        n = 0;
        do begin
            @(negedge iclk);
            n++;
        end while (!(owrite_req || oread_req) && n < 20);
        check("req_lat", DW'(n), DW'(1));
        n = 0;
        while (!oack[p] && n < 100) begin
            @(negedge iclk);
            n++;
        end
        check("ack_seen", DW'(oack[p]), DW'(1));
        ireq[p] = 1'b0;
        @(negedge iclk);
        check("idle_after", DW'(obusy), DW'(0));
        check("ack_clear", DW'(oack), DW'(0));
    endtask

    task automatic wait_acks(input int n);
        int cnt;
        int k;
        cnt = 0;
        k = 0;
        while (cnt < n && k < 500) begin
            @(negedge iclk);
            k++;
            if (oack != '0) cnt++;
        end
        check("acks_done", DW'(cnt), DW'(n));
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (!(owrite_req || oread_req) && k < 20) begin
            @(negedge iclk);
            k++;
        end
        check("req_up", DW'(owrite_req | oread_req), DW'(1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int acks_before;
        ireset = 1'b1; ireq = '0; iwe = '0; iaddr = '0; iwdata = '0;
        man_wack = 1'b0; man_rack = 1'b0; ctl_en = 1'b0; ctl_lat = 10; ctl_rdata = '0;
        repeat (3) @(negedge iclk);
        check("rst_ack", DW'(oack), DW'(0));
        check("rst_grant", DW'(ogrant), DW'(0));
        check("rst_busy", DW'(obusy), DW'(0));
        check("rst_wreq", DW'(owrite_req), DW'(0));
        check("rst_rreq", DW'(oread_req), DW'(0));
        check("rst_ordata", ordata, DW'(0));
        ireset = 1'b0;
        @(negedge iclk);

        // single write from port 1, controller acks after 10 cycles
        ctl_en = 1'b1; ctl_lat = 10; req_cycles = 0; rd_seen = 1'b0;
        do_txn(1, 1'b1, 25'h0000123, 128'h0123456789ABCDEF0123456789ABCDEF);
        check("wr_len", DW'(req_cycles), DW'(10));
        check("no_rd", DW'(rd_seen), DW'(0));

        // single read from port 2
        ctl_lat = 4; ctl_rdata = {4{32'hDEADBEEF}};
        do_txn(2, 1'b0, 25'h1ABCDEF, '0);
        check("rd_hold", ordata, {4{32'hDEADBEEF}});

        // contention: all ports continuously, expect 0,1,2,0,1,2
        ctl_lat = 3; both_seen = 1'b0; ctl_rdata = 128'h55AA_0000_1111_2222_3333_4444_5555_6666;
        setup_port(0, 1'b1, 25'h0000010, 128'hA0A0);
        setup_port(1, 1'b0, 25'h0000020, '0);
        setup_port(2, 1'b1, 25'h0000030, 128'hC0C0);
        for (int r = 0; r < 2; r++) begin
            sb.push_back(mk(0, 1'b1, 25'h0000010, 128'hA0A0));
            sb.push_back(mk(1, 1'b0, 25'h0000020, '0));
            sb.push_back(mk(2, 1'b1, 25'h0000030, 128'hC0C0));
        end
        ireq = 3'b111;
        wait_acks(6);
        ireq = '0;
        repeat (2) @(negedge iclk);
        check("excl_req", DW'(both_seen), DW'(0));
        check("sb_empty", DW'(sb.size()), DW'(0));

        // wrong-direction ack during a write, then stray write ack in IDLE
        ctl_en = 1'b0;
        sb.push_back(mk(0, 1'b1, 25'h0000ABC, 128'h77));
        setup_port(0, 1'b1, 25'h0000ABC, 128'h77);
        ireq[0] = 1'b1;
        wait_req();
        man_rack = 1'b1;
        @(negedge iclk);
        man_rack = 1'b0;
        check("wd_noack", DW'(oack), DW'(0));
        check("wd_busy", DW'(obusy), DW'(1));
        check("wd_wreq", DW'(owrite_req), DW'(1));
        man_wack = 1'b1;
        @(negedge iclk);
        man_wack = 1'b0;
        check("wd_ack", DW'(oack), DW'(1));
        ireq[0] = 1'b0;
        @(negedge iclk);
        acks_before = ack_total;
        man_wack = 1'b1;
        @(negedge iclk);
        man_wack = 1'b0;
        check("stray_busy", DW'(obusy), DW'(0));
        repeat (2) @(negedge iclk);
        check("stray_none", DW'(ack_total), DW'(acks_before));

        // reset in the middle of a write
        sb.push_back(mk(1, 1'b1, 25'h1000001, 128'hFEED));
        setup_port(1, 1'b1, 25'h1000001, 128'hFEED);
        ireq[1] = 1'b1;
        wait_req();
        ireset = 1'b1;
        @(negedge iclk);
        check("mr_busy", DW'(obusy), DW'(0));
        check("mr_wreq", DW'(owrite_req), DW'(0));
        check("mr_grant", DW'(ogrant), DW'(0));
        check("mr_addr", DW'(owrite_address), DW'(0));
        check("mr_ordata", ordata, DW'(0));
        sb.delete();
        last_rd = '0;
        ireset = 1'b0;
        ireq = '0;
        acks_before = ack_total;
        man_wack = 1'b1;
        @(negedge iclk);
        man_wack = 1'b0;
        repeat (3) @(negedge iclk);
        check("mr_late_ack", DW'(ack_total), DW'(acks_before));
        check("mr_idle", DW'(obusy), DW'(0));

`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
        // port 0 wins every time while requesting; port 2 follows once it drops
        ctl_en = 1'b1; ctl_lat = 2;
        setup_port(0, 1'b1, 25'h0000100, 128'h1);
        setup_port(2, 1'b1, 25'h0000200, 128'h2);
        for (int r = 0; r < 3; r++) sb.push_back(mk(0, 1'b1, 25'h0000100, 128'h1));
        sb.push_back(mk(2, 1'b1, 25'h0000200, 128'h2));
        ireq = 3'b101;
        wait_acks(3);
        ireq[0] = 1'b0;
        wait_acks(1);
        ireq = '0;
        repeat (2) @(negedge iclk);
        check("prio_sb_empty", DW'(sb.size()), DW'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
